irq_ctrl: RTL and testbench

//   Interrupt controller upstream of the hazard unit. Latches edge-triggered

---
 rtl/irq_ctrl_if.sv | 30 +++
 rtl/irq_ctrl.sv | 112 +++++++++++
 tb/tb_irq_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// Signal bundle between the interrupt controller and the pipeline (hazard unit / PC mux).
// The pipeline side is the master; the controller is the slave.
interface irq_ctrl_if #(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned XLEN    = 32
);
  logic [NUM_IRQ-1:0] irq_src;
  logic [NUM_IRQ-1:0] irq_en;
  logic               global_ie;
  logic               interrupt_taken;
  logic [XLEN-1:0]    epc_in;
  logic               mret_wb;

  logic               interrupt_req;
  logic [XLEN-1:0]    irq_vector;
  logic [4:0]         irq_cause;
  logic [XLEN-1:0]    mepc;
  logic               in_handler;
  logic               mret_taken;

  modport master (
    output irq_src, irq_en, global_ie, interrupt_taken, epc_in, mret_wb,
    input  interrupt_req, irq_vector, irq_cause, mepc, in_handler, mret_taken
  );

  modport slave (
    input  irq_src, irq_en, global_ie, interrupt_taken, epc_in, mret_wb,
    output interrupt_req, irq_vector, irq_cause, mepc, in_handler, mret_taken
  );
endinterface

// File: rtl/irq_ctrl.sv
// Edge-triggered, fixed-priority, non-nesting interrupt controller with trap vector,
// cause and mepc tracking, plus MRET gating for the hazard unit.
module irq_ctrl #(
  parameter int unsigned     NUM_IRQ    = 8,
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] MTVEC_BASE = 32'h0000_1000,
  parameter int unsigned     VEC_STRIDE = 4
) (
  input logic       clk,
  input logic       rstn,
  irq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReq, StHandler} state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] src_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [4:0]         cause_q, cause_d;
  logic [XLEN-1:0]    mepc_q, mepc_d;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] elig;
  logic [NUM_IRQ-1:0] cause_oh;
  logic [4:0]         elig_idx;
  logic               elig_any;
  logic               cause_en;
  logic               accept;
  logic               mret_ok;

  assign rise     = bus.irq_src & ~src_q;
  assign elig     = pend_q & bus.irq_en;
  assign elig_any = |elig;
  assign cause_oh = NUM_IRQ'(1) << cause_q;
  assign cause_en = |(bus.irq_en & cause_oh);

  // Scan downwards so the lowest eligible index is the last one written.
  always_comb begin
    elig_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        elig_idx = 5'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    mepc_d  = mepc_q;
    accept  = 1'b0;
    mret_ok = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.global_ie && elig_any) begin
          state_d = StReq;
          cause_d = elig_idx;
        end
      end
      StReq: begin
        // Accept takes precedence over a simultaneous withdraw.
        if (bus.interrupt_taken) begin
          accept  = 1'b1;
          mepc_d  = bus.epc_in;
          state_d = StHandler;
        end else if (!bus.global_ie || !cause_en) begin
          state_d = StIdle;
        end
      end
      StHandler: begin
        if (bus.mret_wb) begin
          mret_ok = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A fresh edge on the bit being cleared survives the accept.
  always_comb begin
    pend_d = pend_q;
    if (accept) begin
      pend_d = pend_q & ~cause_oh;
    end
    pend_d = pend_d | rise;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      src_q   <= '0;
      pend_q  <= '0;
      cause_q <= '0;
      mepc_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= bus.irq_src;
      pend_q  <= pend_d;
      cause_q <= cause_d;
      mepc_q  <= mepc_d;
    end
  end

  assign bus.interrupt_req = (state_q == StReq);
  assign bus.in_handler    = (state_q == StHandler);
  assign bus.irq_cause     = cause_q;
  assign bus.mepc          = mepc_q;
  assign bus.mret_taken    = mret_ok;
  assign bus.irq_vector    = MTVEC_BASE + XLEN'(cause_q) * XLEN'(VEC_STRIDE);

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations, then random traffic,
// all cross-checked every cycle against a behavioural model of the controller.
module tb_irq_ctrl;

  logic clk;
  logic rstn;

  irq_ctrl_if #(.NUM_IRQ(8), .XLEN(32)) bus ();

  irq_ctrl #(
    .NUM_IRQ   (8),
    .XLEN      (32),
    .MTVEC_BASE(32'h0000_1000),
    .VEC_STRIDE(4)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: phase 0 = no request, 1 = requesting, 2 = servicing.
  bit [7:0]    m_pend;
  bit [7:0]    m_prev;
  int          m_phase;
  logic [4:0]  m_cause;
  logic [31:0] m_mepc;

  initial begin
    bit [7:0] el;
    bit [7:0] rise;
    bit       found;
    m_pend = '0; m_prev = '0; m_phase = 0; m_cause = '0; m_mepc = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_pend = '0; m_prev = '0; m_phase = 0; m_cause = '0; m_mepc = '0;
      end
      chk("req", 32'(bus.interrupt_req), 32'(m_phase == 1));
      chk("in_handler", 32'(bus.in_handler), 32'(m_phase == 2));
      chk("cause", 32'(bus.irq_cause), 32'(m_cause));
      chk("mepc", bus.mepc, m_mepc);
      chk("mret_taken", 32'(bus.mret_taken), 32'(m_phase == 2 && bus.mret_wb && rstn));
      if (m_phase == 1) chk("vector", bus.irq_vector, 32'h1000 + 32'(m_cause) * 4);
      if (rstn) begin
        el   = m_pend & bus.irq_en;
        rise = bus.irq_src & ~m_prev;
        if (m_phase == 0) begin
          if (bus.global_ie && el != 0) begin
            found = 1'b0;
            for (int i = 0; i < 8; i++) begin
              if (!found && el[i]) begin
                m_cause = 5'(i);
                found   = 1'b1;
              end
            end
            m_phase = 1;
          end
        end else if (m_phase == 1) begin
          if (bus.interrupt_taken) begin
            m_mepc          = bus.epc_in;
            m_pend[m_cause] = 1'b0;
            m_phase         = 2;
          end else if (!bus.global_ie || !bus.irq_en[m_cause]) begin
            m_phase = 0;
          end
        end else if (bus.mret_wb) begin
          m_phase = 0;
        end
        m_pend = m_pend | rise;
        m_prev = bus.irq_src;
      end
    end
  end

  initial begin
    rstn = 1'b0;
    bus.irq_src = '0; bus.irq_en = 8'hFF; bus.global_ie = 1'b1;
    bus.interrupt_taken = 1'b0; bus.epc_in = 32'h200; bus.mret_wb = 1'b0;
    tick(); tick(); tick();
    chk("rst_req", 32'(bus.interrupt_req), 0);
    chk("rst_mepc", bus.mepc, 0);
    rstn = 1'b1;
    tick(); tick();

    // Single IRQ on source 3
    bus.irq_src = 8'h08;
    tick();
    chk("t1_req_early", 32'(bus.interrupt_req), 0);
    tick();
    chk("t1_req", 32'(bus.interrupt_req), 1);
    chk("t1_cause", 32'(bus.irq_cause), 3);
    chk("t1_vector", bus.irq_vector, 32'h100C);
    bus.interrupt_taken = 1'b1;
    tick();
    bus.interrupt_taken = 1'b0;
    bus.irq_src = '0;
    chk("t1_mepc", bus.mepc, 32'h200);
    chk("t1_in_handler", 32'(bus.in_handler), 1);
    chk("t1_req_drop", 32'(bus.interrupt_req), 0);
    bus.mret_wb = 1'b1;
    #1;
    chk("t4_mret_handler", 32'(bus.mret_taken), 1);
    tick();
    chk("t4_in_handler_off", 32'(bus.in_handler), 0);
    chk("t4_mret_idle", 32'(bus.mret_taken), 0);
    bus.mret_wb = 1'b0;

    // Priority: sources 5 and 1 together
    bus.irq_src = 8'h22;
    tick(); tick();
    chk("t2_cause_first", 32'(bus.irq_cause), 1);
    bus.interrupt_taken = 1'b1;
    tick();
    bus.interrupt_taken = 1'b0;
    bus.irq_src = '0;
    bus.mret_wb = 1'b1;
    tick();
    bus.mret_wb = 1'b0;
    chk("t2_gap", 32'(bus.interrupt_req), 0);
    tick();
    chk("t2_req_second", 32'(bus.interrupt_req), 1);
    chk("t2_cause_second", 32'(bus.irq_cause), 5);
    chk("t2_vector_second", bus.irq_vector, 32'h1014);

    // Withdraw by global_ie, then re-request
    bus.global_ie = 1'b0;
    tick();
    chk("t3_withdraw", 32'(bus.interrupt_req), 0);
    bus.global_ie = 1'b1;
    tick();
    chk("t3_rereq", 32'(bus.interrupt_req), 1);
    chk("t3_cause", 32'(bus.irq_cause), 5);
    bus.interrupt_taken = 1'b1;
    tick();
    bus.interrupt_taken = 1'b0;
    bus.mret_wb = 1'b1;
    tick();
    bus.mret_wb = 1'b0;

    // Set/clear collision on source 2
    bus.irq_src = 8'h04;
    tick();
    bus.irq_src = 8'h00;
    tick();
    chk("t5_cause", 32'(bus.irq_cause), 2);
    bus.interrupt_taken = 1'b1;
    bus.irq_src = 8'h04;
    tick();
    bus.interrupt_taken = 1'b0;
    bus.mret_wb = 1'b1;
    tick();
    bus.mret_wb = 1'b0;
    tick();
    chk("t5_rereq", 32'(bus.interrupt_req), 1);
    chk("t5_rereq_cause", 32'(bus.irq_cause), 2);
    bus.interrupt_taken = 1'b1;
    tick();
    bus.interrupt_taken = 1'b0;
    bus.mret_wb = 1'b1;
    tick();
    bus.mret_wb = 1'b0;

    // Reset while servicing with four sources pending
    bus.irq_src = '0;
    tick();
    bus.irq_src = 8'h0F;
    tick(); tick();
    chk("t6_cause0", 32'(bus.irq_cause), 0);
    bus.interrupt_taken = 1'b1;
    bus.irq_src = 8'h0E;
    tick();
    bus.interrupt_taken = 1'b0;
    bus.irq_src = 8'h0F;
    tick();
    chk("t6_in_handler", 32'(bus.in_handler), 1);
    chk("t6_mepc_pre", bus.mepc, 32'h200);
    rstn = 1'b0;
    bus.irq_src = '0;
    #1;
    chk("t6_rst_in_handler", 32'(bus.in_handler), 0);
    chk("t6_rst_mepc", bus.mepc, 0);
    chk("t6_rst_cause", 32'(bus.irq_cause), 0);
    tick();
    rstn = 1'b1;
    tick(); tick(); tick(); tick();
    chk("t6_no_req", 32'(bus.interrupt_req), 0);

    // Random traffic, checked by the model
    repeat (3000) begin
      tick();
      if ($urandom_range(0, 3) == 0) bus.irq_src = bus.irq_src ^ 8'(1 << $urandom_range(0, 7));
      bus.irq_en          = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hFF;
      bus.global_ie       = ($urandom_range(0, 9) != 0);
      bus.interrupt_taken = ($urandom_range(0, 2) == 0);
      bus.mret_wb         = ($urandom_range(0, 4) == 0);
      bus.epc_in          = $urandom;
      rstn                = ($urandom_range(0, 499) != 0);
    end
    rstn = 1'b1;
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
